// File: rtl/input_conditioner_pkg.sv
// Shared constants, types and helpers for the input conditioner.
// Optional feature macro used by the design: INPUT_CONDITIONER_TOGGLE_OUT_EN.
package input_conditioner_pkg;

  localparam int MIN_SYNC_STAGES = 2;

  typedef struct packed {
    logic rise;
    logic fall;
  } edge_t;

  // Counter width for a debounce window; at least one bit even for a 1-cycle window.
  function automatic int cnt_width(input int cycles);
    int w;
    w = $clog2(cycles);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One channel of debounce: consecutive-sample counter, stable level, rise/fall pulses.
// With INPUT_CONDITIONER_TOGGLE_OUT_EN a toggle flop flips once per rise pulse.
module debounce_channel
  import input_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  sync_i,
  output logic  stable_o,
  output edge_t edge_o
`ifdef INPUT_CONDITIONER_TOGGLE_OUT_EN
  ,
  output logic  toggle_o
`endif
);

  localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_cycles
    $error("debounce_channel: DEBOUNCE_CYCLES must be 1 or more");
  end

  logic [CW-1:0] cnt_q, cnt_d;
  logic          stable_q, stable_d;
  edge_t         edge_q, edge_d;

  always_comb begin
    // NOTE: every signal written here gets a default first; a path that leaves one unassigned infers a latch.
    cnt_d    = cnt_q;
    stable_d = stable_q;
    edge_d   = '0;
    if (sync_i == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      // The window is complete: adopt the new level and pulse in the same cycle.
      stable_d    = sync_i;
      cnt_d       = '0;
      edge_d.rise = sync_i;
      edge_d.fall = ~sync_i;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so each flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
      edge_q   <= '0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      edge_q   <= edge_d;
    end
  end

  assign stable_o = stable_q;
  assign edge_o   = edge_q;

`ifdef INPUT_CONDITIONER_TOGGLE_OUT_EN
  logic toggle_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      toggle_q <= 1'b0;
    end else begin
      toggle_q <= toggle_q ^ edge_q.rise;
    end
  end

  assign toggle_o = toggle_q;
`endif

endmodule

// File: rtl/input_conditioner.sv
// Multi-channel input front end: N-stage synchronizer, debounce and edge pulses per channel.
// Defining INPUT_CONDITIONER_TOGGLE_OUT_EN adds a per-channel toggle output.
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int WIDTH           = 16,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] signal,
  output logic [WIDTH-1:0] sync_signal,
  output logic [WIDTH-1:0] stable,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
`ifdef INPUT_CONDITIONER_TOGGLE_OUT_EN
  ,
  output logic [WIDTH-1:0] toggle
`endif
);

  if (SYNC_STAGES < MIN_SYNC_STAGES) begin : g_bad_sync
    $error("input_conditioner: SYNC_STAGES must be 2 or more");
  end

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;

  // NOTE: the synchronizer array is reset like any other flop so sync_signal has a defined level out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= signal;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign sync_signal = sync_q[SYNC_STAGES-1];

  edge_t [WIDTH-1:0] edges;

  for (genvar g = 0; g < WIDTH; g++) begin : g_chan
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_chan (
      .clk     (clk),
      .reset   (reset),
      .sync_i  (sync_signal[g]),
      .stable_o(stable[g]),
      .edge_o  (edges[g])
`ifdef INPUT_CONDITIONER_TOGGLE_OUT_EN
      ,
      .toggle_o(toggle[g])
`endif
    );

    assign rise[g] = edges[g].rise;
    assign fall[g] = edges[g].fall;
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench: directed scenarios plus random stimulus against a history-window model.
// Two instances: defaults (S=2, D=4) and a fast path (S=3, D=1).
module tb_input_conditioner;

  localparam int W = 16;

  logic         clk    = 1'b0;
  logic         reset  = 1'b1;
  logic [W-1:0] signal = '0;

  logic [W-1:0] sync0, stable0, rise0, fall0;
  logic [W-1:0] sync1, stable1, rise1, fall1;
`ifdef INPUT_CONDITIONER_TOGGLE_OUT_EN
  logic [W-1:0] toggle0, toggle1;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  input_conditioner #(.WIDTH(W), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) u_dut0 (
    .clk(clk), .reset(reset), .signal(signal), .sync_signal(sync0),
    .stable(stable0), .rise(rise0), .fall(fall0)
`ifdef INPUT_CONDITIONER_TOGGLE_OUT_EN
    , .toggle(toggle0)
`endif
  );

  input_conditioner #(.WIDTH(W), .SYNC_STAGES(3), .DEBOUNCE_CYCLES(1)) u_dut1 (
    .clk(clk), .reset(reset), .signal(signal), .sync_signal(sync1),
    .stable(stable1), .rise(rise1), .fall(fall1)
`ifdef INPUT_CONDITIONER_TOGGLE_OUT_EN
    , .toggle(toggle1)
`endif
  );

  // Reference model: stable flips once the last D synchronized samples all differ from it.
  int           ms[2] = '{2, 3};
  int           md[2] = '{4, 1};
  logic [W-1:0] hist[2][16];
  logic [W-1:0] m_sync[2], m_stb[2], m_rise[2], m_fall[2], m_tog[2];

  task automatic model_step(input int m);
    logic [W-1:0] nr, nf;
    bit           diff;
    if (reset) begin
      for (int j = 0; j < 16; j++) hist[m][j] = '0;
      m_sync[m] = '0; m_stb[m] = '0; m_rise[m] = '0; m_fall[m] = '0; m_tog[m] = '0;
    end else begin
      m_tog[m] = m_tog[m] ^ m_rise[m];
      for (int j = 15; j > 0; j--) hist[m][j] = hist[m][j-1];
      hist[m][0] = signal;
      m_sync[m] = hist[m][ms[m]-1];
      nr = '0;
      nf = '0;
      for (int c = 0; c < W; c++) begin
        diff = 1'b1;
        for (int j = ms[m]; j < ms[m] + md[m]; j++)
          if (hist[m][j][c] == m_stb[m][c]) diff = 1'b0;
        if (diff) begin
          m_stb[m][c] = ~m_stb[m][c];
          if (m_stb[m][c]) nr[c] = 1'b1; else nf[c] = 1'b1;
        end
      end
      m_rise[m] = nr;
      m_fall[m] = nf;
    end
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
  end

  function automatic logic [63:0] act(input int m);
    return (m == 0) ? {sync0, stable0, rise0, fall0} : {sync1, stable1, rise1, fall1};
  endfunction

  function automatic logic [63:0] exp_v(input int m);
    return {m_sync[m], m_stb[m], m_rise[m], m_fall[m]};
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      signal = W'($urandom);
      @(negedge clk);
      checks++;
      if ({act(0), act(1)} !== '0) begin
        failures++;
        $display("FAIL reset_values cyc%0d act=%h exp=0", k, {act(0), act(1)});
      end
    end
    signal = '0;
    reset  = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++;
      if ({rise0, fall0, rise1, fall1, stable0, stable1} !== '0) begin
        failures++;
        $display("FAIL reset_quiet cyc%0d act=%h exp=0", k, {rise0, fall0, rise1, fall1, stable0, stable1});
      end
    end
  endtask

  task automatic test_single_rise();
    logic [3:0] e;
    signal[0] = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      e = {1'(k >= 2), 1'(k >= 6), 1'(k == 6), 1'b0};
      checks++;
      if ({sync0[0], stable0[0], rise0[0], fall0[0]} !== e) begin
        failures++;
        $display("FAIL single_rise_ch0 edge%0d act=%b exp=%b", k, {sync0[0], stable0[0], rise0[0], fall0[0]}, e);
      end
      checks++;
      if ({sync0[W-1:1], stable0[W-1:1], rise0[W-1:1], fall0[W-1:1]} !== '0) begin
        failures++;
        $display("FAIL single_rise_others edge%0d act=%h exp=0", k, {sync0[W-1:1], stable0[W-1:1], rise0[W-1:1], fall0[W-1:1]});
      end
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (act(m) !== exp_v(m)) begin
          failures++;
          $display("FAIL single_rise_model dut%0d edge%0d act=%h exp=%h", m, k, act(m), exp_v(m));
        end
      end
    end
    signal = '0;
    idle(10);
  endtask

  task automatic test_glitch();
    signal[3] = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (k == 3) signal[3] = 1'b0;
      checks++;
      if ({stable0[3], rise0[3], fall0[3]} !== 3'b000) begin
        failures++;
        $display("FAIL glitch_reject edge%0d act=%b exp=000", k, {stable0[3], rise0[3], fall0[3]});
      end
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (act(m) !== exp_v(m)) begin
          failures++;
          $display("FAIL glitch_model dut%0d edge%0d act=%h exp=%h", m, k, act(m), exp_v(m));
        end
      end
    end
  endtask

  task automatic test_all_channels();
    logic [W-1:0] es, er, ef;
    for (int ph = 0; ph < 2; ph++) begin
      signal = (ph == 0) ? {W{1'b1}} : '0;
      for (int k = 1; k <= 8; k++) begin
        @(negedge clk);
        es = ((ph == 0) == (k >= 6)) ? {W{1'b1}} : '0;
        er = (ph == 0 && k == 6) ? {W{1'b1}} : '0;
        ef = (ph == 1 && k == 6) ? {W{1'b1}} : '0;
        checks++;
        if ({stable0, rise0, fall0} !== {es, er, ef}) begin
          failures++;
          $display("FAIL all_channels ph%0d edge%0d act=%h exp=%h", ph, k, {stable0, rise0, fall0}, {es, er, ef});
        end
        for (int m = 0; m < 2; m++) begin
          checks++;
          if (act(m) !== exp_v(m)) begin
            failures++;
            $display("FAIL all_channels_model dut%0d ph%0d edge%0d act=%h exp=%h", m, ph, k, act(m), exp_v(m));
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid_count();
    logic [W-1:0] er;
    signal[5] = 1'b1;
    idle(4);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({stable0[5], rise0, fall0} !== '0) begin
      failures++;
      $display("FAIL reset_mid_count_clear act=%h exp=0", {stable0[5], rise0, fall0});
    end
    reset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      er = (k == 6) ? W'(1 << 5) : '0;
      checks++;
      if ({stable0[5], rise0, fall0} !== {1'(k >= 6), er, {W{1'b0}}}) begin
        failures++;
        $display("FAIL reset_mid_count edge%0d act=%h exp=%h", k, {stable0[5], rise0, fall0}, {1'(k >= 6), er, {W{1'b0}}});
      end
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (act(m) !== exp_v(m)) begin
          failures++;
          $display("FAIL reset_mid_count_model dut%0d edge%0d act=%h exp=%h", m, k, act(m), exp_v(m));
        end
      end
    end
    signal = '0;
    idle(10);
  endtask

  task automatic test_fast_path();
    logic v[0:16];
    logic es, prev;
    v[0] = 1'b0;
    for (int j = 1; j <= 16; j++) begin
      v[j] = 1'(j % 2);
      signal[1] = v[j];
      @(negedge clk);
      es   = (j >= 3) ? v[j-3] : 1'b0;
      prev = (j >= 4) ? v[j-4] : 1'b0;
      checks++;
      if ({stable1[1], rise1[1], fall1[1]} !== {es, es & ~prev, ~es & prev}) begin
        failures++;
        $display("FAIL fast_path edge%0d act=%b exp=%b", j, {stable1[1], rise1[1], fall1[1]}, {es, es & ~prev, ~es & prev});
      end
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (act(m) !== exp_v(m)) begin
          failures++;
          $display("FAIL fast_path_model dut%0d edge%0d act=%h exp=%h", m, j, act(m), exp_v(m));
        end
      end
    end
    signal = '0;
    idle(10);
  endtask

`ifdef INPUT_CONDITIONER_TOGGLE_OUT_EN
  task automatic test_toggle();
    logic et;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int p = 0; p < 3; p++) begin
      signal[2] = 1'b1;
      for (int k = 1; k <= 10; k++) begin
        @(negedge clk);
        et = 1'((p + ((k >= 7) ? 1 : 0)) % 2);
        checks++;
        if ({toggle0[2], rise0[2]} !== {et, 1'(k == 6)}) begin
          failures++;
          $display("FAIL toggle press%0d edge%0d act=%b exp=%b", p, k, {toggle0[2], rise0[2]}, {et, 1'(k == 6)});
        end
      end
      signal[2] = 1'b0;
      idle(10);
    end
    checks++;
    if (toggle0[2] !== 1'b1) begin
      failures++;
      $display("FAIL toggle_final act=%b exp=1", toggle0[2]);
    end
  endtask
`endif

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 3) == 0)
        signal = signal ^ (W'($urandom) & W'($urandom) & W'($urandom));
      reset = ($urandom_range(0, 63) == 0);
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (act(m) !== exp_v(m)) begin
          failures++;
          $display("FAIL random_model dut%0d cyc%0d act=%h exp=%h", m, k, act(m), exp_v(m));
        end
      end
      checks++;
      if (((rise0 & fall0) | (rise1 & fall1)) !== '0) begin
        failures++;
        $display("FAIL random_rise_fall_overlap cyc%0d act=%h exp=0", k, (rise0 & fall0) | (rise1 & fall1));
      end
`ifdef INPUT_CONDITIONER_TOGGLE_OUT_EN
      checks++;
      if ({toggle0, toggle1} !== {m_tog[0], m_tog[1]}) begin
        failures++;
        $display("FAIL random_toggle cyc%0d act=%h exp=%h", k, {toggle0, toggle1}, {m_tog[0], m_tog[1]});
      end
`endif
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_rise();
    test_glitch();
    test_all_channels();
    test_reset_mid_count();
    test_fast_path();
`ifdef INPUT_CONDITIONER_TOGGLE_OUT_EN
    test_toggle();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
Parametrised multi-channel input front end that supersedes the fixed 16-bit two-flop synchronizer. Each channel gets an N-stage metastability synchronizer, a consecutive-sample debounce filter and one-cycle rise/fall pulse generation. It sits between asynchronous board inputs (switches, buttons) and all downstream logic that consumes them.

Parameters:
- WIDTH, 16, number of independent channels.
- SYNC_STAGES, 2, flops in each synchronizer chain; legal range is 2 or more (elaboration error otherwise).
- DEBOUNCE_CYCLES, 4, consecutive synchronized samples that must differ from the stable level before it changes; legal range is 1 or more.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- signal  input  WIDTH  asynchronous raw inputs.
- sync_signal  output  WIDTH  last synchronizer stage per channel (undebounced).
- stable  output  WIDTH  debounced level per channel.
- rise  output  WIDTH  one-cycle pulse when stable goes 0->1.
- fall  output  WIDTH  one-cycle pulse when stable goes 1->0.
- toggle  output  WIDTH  present only with TOGGLE_OUT_EN (see Optional Feature).

Behaviour:
- Interface: reset is synchronous, active-high; clock is clk. All flops update on posedge clk only.
- Reset values: every synchronizer stage, sync_signal, stable, rise, fall, toggle and all counters are 0.
- Synchronizer:
  - stage[0] <= signal; stage[i] <= stage[i-1]; sync_signal = stage[SYNC_STAGES-1].
  - Latency from signal to sync_signal is SYNC_STAGES edges.
- Debounce, per channel, counter width max(1, $clog2(DEBOUNCE_CYCLES)):
  - If sync_signal == stable: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: stable <= sync_signal, cnt <= 0.
  - Else: cnt <= cnt+1.
- Debounce timing:
  - A change held on signal appears on stable after exactly SYNC_STAGES + DEBOUNCE_CYCLES edges.
  - A synchronized pulse shorter than DEBOUNCE_CYCLES cycles is rejected and cnt returns to 0.
  - DEBOUNCE_CYCLES=1 means stable is sync_signal delayed by one register.
  - cnt never exceeds DEBOUNCE_CYCLES-1 (no wrap).
- Edge pulses:
  - rise[i] and fall[i] are registered and assert in the same cycle stable[i] takes its new value, for exactly one cycle.
  - rise and fall are never both high on a channel.
  - A sustained level never re-pulses.
- Channels are fully independent. Simultaneous changes on any subset of channels produce simultaneous pulses on that subset.
- Reset mid-count: counters clear, stable returns to 0, and no pulse is emitted on the reset cycle or on the first cycle after reset.
  - A channel whose input is held at 1 through reset produces a rise SYNC_STAGES + DEBOUNCE_CYCLES edges after reset deasserts.

Optional Feature:
- Macro: INPUT_CONDITIONER_TOGGLE_OUT_EN.
- Defined:
  - toggle port exists.
  - toggle[i] inverts on each cycle where rise[i] is asserted, so it changes one edge after the rise pulse.
  - toggle resets to 0.
- Undefined: toggle port and its flops are absent; all other behaviour is identical.

Decomposition:
- Package input_conditioner_pkg holds:
  - MIN_SYNC_STAGES = 2.
  - function cnt_width(int cycles), returning max(1, $clog2(cycles)).
  - typedef edge_t, a struct of logic rise and logic fall.
- Sub-module debounce_channel: one channel's counter, stable flop, edge flops and optional toggle. Instantiate it WIDTH times in a generate loop.
- The synchronizer chain stays in the top level as a 2-D register array.

Test Plan:
1. Defaults; signal[0] 0->1 and held. Required: sync_signal[0]=1 after 2 edges; stable[0]=1 and rise[0]=1 for one cycle after 6 edges; fall stays 0 and other channels stay 0.
2. Defaults; signal[3] high for 3 cycles, then low. Required: stable[3], rise[3] and fall[3] stay 0 throughout.
3. Defaults; signal=16'hFFFF, then 16'h0000 after stable settles. Required: rise=16'hFFFF for one cycle, then fall=16'hFFFF for one cycle, 6 edges after each change.
4. Defaults; signal[5]=1 and reset pulsed for 1 cycle when cnt=2. Required: stable[5]=0 with no pulse during reset; rise[5] asserts 6 edges after reset deasserts.
5. DEBOUNCE_CYCLES=1, SYNC_STAGES=3; alternate signal[1] every cycle. Required: stable[1] follows signal[1] delayed by 4 edges, with rise and fall alternating each cycle.
6. INPUT_CONDITIONER_TOGGLE_OUT_EN defined; three debounced presses on channel 2. Required: toggle[2] sequence 0->1->0->1, each change one edge after rise[2].
